// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I-subset execute stage.
//   XLEN / REG_AW : datapath and register-address widths
//   ALU_*         : ALUControl encodings
//   FWD_*         : operand forward-select codes (used when FORWARDING_EN is defined)
//   ex_mem_t      : EX/MEM pipeline register contents
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_write;
    logic              result_src;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc_plus4;
  } ex_mem_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU.
//   a_i, b_i       : operands
//   alu_control_i  : operation (ALU_ADD/SUB/AND/OR/SLT; other codes give 0)
//   result_o       : result, modulo 2^XLEN
//   zero_o         : result == 0
module alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [2:0]      alu_control_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  always_comb begin
    result_o = '0;
    case (alu_control_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, beq resolution and the EX/MEM pipeline register.
// Optional feature macro: FORWARDING_EN (adds ForwardA_E, ForwardB_E, Result_W and operand
// forwarding muxes; without it operands come straight from RD1_E/RD2_E).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   *_E inputs           : ID/EX control word and operands
//   stall_M, flush_M     : hold / bubble the EX/MEM register (flush wins)
//   PCSrc_E, PCTarget_E  : combinational branch decision and target back to fetch
//   *_M outputs          : registered EX/MEM contents
module execute_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_E,
  input  logic              RegWrite_E,
  input  logic              ALUSrc_E,
  input  logic              MemWrite_E,
  input  logic              ResultSrc_E,
  input  logic              Branch_E,
  input  logic [2:0]        ALUControl_E,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   Imm_Ext_E,
  input  logic [XLEN-1:0]   PC_E,
  input  logic [XLEN-1:0]   PCPlus4_E,
  input  logic [REG_AW-1:0] Rd_E,
  input  logic              stall_M,
  input  logic              flush_M,
`ifdef FORWARDING_EN
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [XLEN-1:0]   Result_W,
`endif
  output logic              PCSrc_E,
  output logic [XLEN-1:0]   PCTarget_E,
  output logic              valid_M,
  output logic              RegWrite_M,
  output logic              MemWrite_M,
  output logic              ResultSrc_M,
  output logic [XLEN-1:0]   ALUResult_M,
  output logic [XLEN-1:0]   WriteData_M,
  output logic [REG_AW-1:0] Rd_M,
  output logic [XLEN-1:0]   PCPlus4_M
);

  ex_mem_t ex_mem_d, ex_mem_q;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b_reg;  // B operand before the immediate mux; also the store data
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

`ifdef FORWARDING_EN
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      FWD_MEM: src_a = ex_mem_q.alu_result;
      FWD_WB:  src_a = Result_W;
      default: src_a = RD1_E;  // 11 behaves as 00
    endcase
  end

  always_comb begin
    src_b_reg = RD2_E;
    case (ForwardB_E)
      FWD_MEM: src_b_reg = ex_mem_q.alu_result;
      FWD_WB:  src_b_reg = Result_W;
      default: src_b_reg = RD2_E;
    endcase
  end
`else
  assign src_a     = RD1_E;
  assign src_b_reg = RD2_E;
`endif

  assign src_b = ALUSrc_E ? Imm_Ext_E : src_b_reg;

  alu u_alu (
    .a_i           (src_a),
    .b_i           (src_b),
    .alu_control_i (ALUControl_E),
    .result_o      (alu_result),
    .zero_o        (alu_zero)
  );

  // Branch resolution relies on decode selecting sub for beq.
  assign PCSrc_E    = valid_E & Branch_E & alu_zero;
  assign PCTarget_E = PC_E + Imm_Ext_E;

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.valid      = valid_E;
    ex_mem_d.reg_write  = RegWrite_E & valid_E;
    ex_mem_d.mem_write  = MemWrite_E & valid_E;
    ex_mem_d.result_src = ResultSrc_E;
    ex_mem_d.alu_result = alu_result;
    ex_mem_d.write_data = src_b_reg;
    ex_mem_d.rd         = Rd_E;
    ex_mem_d.pc_plus4   = PCPlus4_E;
  end

  // Priority: reset, then flush (bubble), then stall (hold), then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_q <= '0;
    end else if (flush_M) begin
      ex_mem_q <= '0;
    end else if (!stall_M) begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign valid_M     = ex_mem_q.valid;
  assign RegWrite_M  = ex_mem_q.reg_write;
  assign MemWrite_M  = ex_mem_q.mem_write;
  assign ResultSrc_M = ex_mem_q.result_src;
  assign ALUResult_M = ex_mem_q.alu_result;
  assign WriteData_M = ex_mem_q.write_data;
  assign Rd_M        = ex_mem_q.rd;
  assign PCPlus4_M   = ex_mem_q.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage, plus hand-written reset, stall/flush and
// (when FORWARDING_EN is defined) forwarding sequences.
module tb_execute_stage;
  import riscv_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_E, RegWrite_E, ALUSrc_E, MemWrite_E, ResultSrc_E, Branch_E;
  logic [2:0]        ALUControl_E;
  logic [XLEN-1:0]   RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E;
  logic [REG_AW-1:0] Rd_E;
  logic              stall_M, flush_M;
`ifdef FORWARDING_EN
  logic [1:0]        ForwardA_E, ForwardB_E;
  logic [XLEN-1:0]   Result_W;
`endif
  logic              PCSrc_E;
  logic [XLEN-1:0]   PCTarget_E;
  logic              valid_M, RegWrite_M, MemWrite_M, ResultSrc_M;
  logic [XLEN-1:0]   ALUResult_M, WriteData_M, PCPlus4_M;
  logic [REG_AW-1:0] Rd_M;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk          (clk),
    .rst          (rst),
    .valid_E      (valid_E),
    .RegWrite_E   (RegWrite_E),
    .ALUSrc_E     (ALUSrc_E),
    .MemWrite_E   (MemWrite_E),
    .ResultSrc_E  (ResultSrc_E),
    .Branch_E     (Branch_E),
    .ALUControl_E (ALUControl_E),
    .RD1_E        (RD1_E),
    .RD2_E        (RD2_E),
    .Imm_Ext_E    (Imm_Ext_E),
    .PC_E         (PC_E),
    .PCPlus4_E    (PCPlus4_E),
    .Rd_E         (Rd_E),
    .stall_M      (stall_M),
    .flush_M      (flush_M),
`ifdef FORWARDING_EN
    .ForwardA_E   (ForwardA_E),
    .ForwardB_E   (ForwardB_E),
    .Result_W     (Result_W),
`endif
    .PCSrc_E      (PCSrc_E),
    .PCTarget_E   (PCTarget_E),
    .valid_M      (valid_M),
    .RegWrite_M   (RegWrite_M),
    .MemWrite_M   (MemWrite_M),
    .ResultSrc_M  (ResultSrc_M),
    .ALUResult_M  (ALUResult_M),
    .WriteData_M  (WriteData_M),
    .Rd_M         (Rd_M),
    .PCPlus4_M    (PCPlus4_M)
  );

  typedef struct {
    logic        valid, regw, alusrc, memw, ressrc, branch;
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd;
    logic        e_pcsrc;
    logic [31:0] e_target, e_alu, e_wdata;
    logic        e_valid, e_regw, e_memw;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".valid_M"}, {31'b0, valid_M}, 32'h0);
    chk({name, ".RegWrite_M"}, {31'b0, RegWrite_M}, 32'h0);
    chk({name, ".MemWrite_M"}, {31'b0, MemWrite_M}, 32'h0);
    chk({name, ".ResultSrc_M"}, {31'b0, ResultSrc_M}, 32'h0);
    chk({name, ".ALUResult_M"}, ALUResult_M, 32'h0);
    chk({name, ".WriteData_M"}, WriteData_M, 32'h0);
    chk({name, ".Rd_M"}, {27'b0, Rd_M}, 32'h0);
    chk({name, ".PCPlus4_M"}, PCPlus4_M, 32'h0);
  endtask

  task automatic idle_inputs();
    valid_E = 0; RegWrite_E = 0; ALUSrc_E = 0; MemWrite_E = 0; ResultSrc_E = 0; Branch_E = 0;
    ALUControl_E = ALU_ADD; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PC_E = 0; PCPlus4_E = 0;
    Rd_E = 0; stall_M = 0; flush_M = 0;
`ifdef FORWARDING_EN
    ForwardA_E = FWD_NONE; ForwardB_E = FWD_NONE; Result_W = 0;
`endif
  endtask

  task automatic drive_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    valid_E = 1; RegWrite_E = 1; ALUSrc_E = 0; MemWrite_E = 0; ResultSrc_E = 0; Branch_E = 0;
    ALUControl_E = op; RD1_E = a; RD2_E = b; Imm_Ext_E = 0; PC_E = 32'h40; PCPlus4_E = 32'h44;
    Rd_E = rd;
  endtask

  function automatic vec_t mk(input logic valid, regw, alusrc, memw, ressrc, branch,
                              input logic [2:0] op, input logic [31:0] rd1, rd2, imm, pc,
                              input logic e_pcsrc, input logic [31:0] e_target, e_alu, e_wdata);
    vec_t v;
    v.valid = valid; v.regw = regw; v.alusrc = alusrc; v.memw = memw; v.ressrc = ressrc;
    v.branch = branch; v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.pc = pc;
    v.pc4 = pc + 32'd4; v.rd = 5'd7; v.e_pcsrc = e_pcsrc; v.e_target = e_target;
    v.e_alu = e_alu; v.e_wdata = e_wdata; v.e_valid = valid;
    v.e_regw = regw & valid; v.e_memw = memw & valid;
    return v;
  endfunction

  initial begin
    //          vld rw src mw rs br op       rd1           rd2           imm           pc
    //          pcsrc target        alu           wdata
    vecs[0]  = mk(1, 1, 0, 0, 0, 0, ALU_ADD, 32'd7,        32'd5,        32'd0,        32'd0,
                  0, 32'h0,         32'd12,       32'd5);
    vecs[1]  = mk(1, 1, 0, 0, 1, 0, ALU_SUB, 32'd7,        32'd5,        32'd0,        32'd0,
                  0, 32'h0,         32'd2,        32'd5);
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, ALU_AND, 32'd7,        32'd5,        32'd0,        32'd0,
                  0, 32'h0,         32'd5,        32'd5);
    vecs[3]  = mk(1, 1, 0, 0, 0, 0, ALU_OR,  32'd7,        32'd5,        32'd0,        32'd0,
                  0, 32'h0,         32'd7,        32'd5);
    vecs[4]  = mk(1, 1, 0, 0, 0, 0, ALU_SLT, 32'd7,        32'd5,        32'd0,        32'd0,
                  0, 32'h0,         32'd0,        32'd5);
    vecs[5]  = mk(1, 1, 0, 0, 0, 0, ALU_SLT, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,
                  0, 32'h0,         32'd1,        32'd1);
    vecs[6]  = mk(1, 0, 0, 0, 0, 1, ALU_SUB, 32'h10,       32'h10,       32'hFFFFFFF8, 32'h100,
                  1, 32'hF8,        32'd0,        32'h10);
    vecs[7]  = mk(1, 0, 0, 0, 0, 1, ALU_SUB, 32'h10,       32'h11,       32'hFFFFFFF8, 32'h100,
                  0, 32'hF8,        32'hFFFFFFFF, 32'h11);
    vecs[8]  = mk(0, 1, 0, 1, 0, 1, ALU_SUB, 32'h10,       32'h10,       32'h8,        32'h200,
                  0, 32'h208,       32'd0,        32'h10);
    vecs[9]  = mk(1, 0, 1, 1, 0, 0, ALU_ADD, 32'h10,       32'h99,       32'h4,        32'h0,
                  0, 32'h4,         32'h14,       32'h99);
    vecs[10] = mk(1, 1, 0, 0, 0, 0, 3'b111,  32'h12,       32'h34,       32'h0,        32'h0,
                  0, 32'h0,         32'h0,        32'h34);
    vecs[11] = mk(1, 1, 0, 0, 0, 0, ALU_ADD, 32'hFFFFFFFF, 32'h1,        32'h10,       32'hFFFFFFF8,
                  0, 32'h8,         32'h0,        32'h1);

    // Reset with random inputs; valid_E forced low to also observe PCSrc_E.
    rst = 1;
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      RegWrite_E = 1'($urandom); MemWrite_E = 1'($urandom); ResultSrc_E = 1'($urandom);
      ALUSrc_E = 1'($urandom); Branch_E = 1; valid_E = 0; ALUControl_E = ALU_SUB;
      RD1_E = $urandom; RD2_E = RD1_E; Imm_Ext_E = $urandom; PC_E = $urandom;
      PCPlus4_E = $urandom; Rd_E = 5'($urandom);
      stall_M = 1'($urandom); flush_M = 1'($urandom);
      #1 chk("reset.PCSrc_E", {31'b0, PCSrc_E}, 32'h0);
      @(posedge clk); #1 chk_zero("reset");
    end
    @(negedge clk);
    rst = 0;
    idle_inputs();

    // Table-driven ALU/branch/invalid-slot vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      valid_E = vecs[i].valid; RegWrite_E = vecs[i].regw; ALUSrc_E = vecs[i].alusrc;
      MemWrite_E = vecs[i].memw; ResultSrc_E = vecs[i].ressrc; Branch_E = vecs[i].branch;
      ALUControl_E = vecs[i].op; RD1_E = vecs[i].rd1; RD2_E = vecs[i].rd2;
      Imm_Ext_E = vecs[i].imm; PC_E = vecs[i].pc; PCPlus4_E = vecs[i].pc4; Rd_E = vecs[i].rd;
      #1;
      chk($sformatf("v%0d.PCSrc_E", i), {31'b0, PCSrc_E}, {31'b0, vecs[i].e_pcsrc});
      chk($sformatf("v%0d.PCTarget_E", i), PCTarget_E, vecs[i].e_target);
      @(posedge clk); #1;
      chk($sformatf("v%0d.ALUResult_M", i), ALUResult_M, vecs[i].e_alu);
      chk($sformatf("v%0d.WriteData_M", i), WriteData_M, vecs[i].e_wdata);
      chk($sformatf("v%0d.valid_M", i), {31'b0, valid_M}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d.RegWrite_M", i), {31'b0, RegWrite_M}, {31'b0, vecs[i].e_regw});
      chk($sformatf("v%0d.MemWrite_M", i), {31'b0, MemWrite_M}, {31'b0, vecs[i].e_memw});
      chk($sformatf("v%0d.ResultSrc_M", i), {31'b0, ResultSrc_M}, {31'b0, vecs[i].ressrc});
      chk($sformatf("v%0d.Rd_M", i), {27'b0, Rd_M}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d.PCPlus4_M", i), PCPlus4_M, vecs[i].pc4);
    end

    // Stall holds 9 for three cycles while a different op sits in EX.
    @(negedge clk);
    idle_inputs();
    drive_alu(ALU_ADD, 32'd4, 32'd5, 5'd9);
    @(posedge clk); #1 chk("stall.load", ALUResult_M, 32'd9);
    @(negedge clk);
    drive_alu(ALU_ADD, 32'd1, 32'd1, 5'd2);
    stall_M = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d.ALUResult_M", c), ALUResult_M, 32'd9);
      chk($sformatf("stall%0d.Rd_M", c), {27'b0, Rd_M}, 32'd9);
      chk($sformatf("stall%0d.valid_M", c), {31'b0, valid_M}, 32'd1);
    end
    @(negedge clk);
    flush_M = 1;
    @(posedge clk); #1 chk_zero("stall_flush");
    @(negedge clk);
    stall_M = 0; flush_M = 0;
    @(posedge clk); #1 chk("after_flush.ALUResult_M", ALUResult_M, 32'd2);

    // Reset mid-operation drops the in-flight entry.
    @(negedge clk);
    drive_alu(ALU_OR, 32'hF0, 32'h0F, 5'd3);
    rst = 1;
    @(posedge clk); #1 chk_zero("mid_reset");
    @(negedge clk);
    rst = 0;

`ifdef FORWARDING_EN
    @(negedge clk);
    idle_inputs();
    drive_alu(ALU_ADD, 32'h20, 32'h0, 5'd4);
    @(posedge clk); #1 chk("fwd.setup", ALUResult_M, 32'h20);
    @(negedge clk);
    drive_alu(ALU_ADD, 32'h0, 32'h1, 5'd5);
    ForwardA_E = FWD_MEM;
    @(posedge clk); #1 chk("fwd.A_mem", ALUResult_M, 32'h21);
    @(negedge clk);
    drive_alu(ALU_ADD, 32'h0, 32'h3, 5'd6);
    ForwardA_E = FWD_NONE; ForwardB_E = FWD_WB; Result_W = 32'h55; MemWrite_E = 1;
    @(posedge clk); #1;
    chk("fwd.B_wb.WriteData_M", WriteData_M, 32'h55);
    chk("fwd.B_wb.ALUResult_M", ALUResult_M, 32'h55);
    chk("fwd.B_wb.MemWrite_M", {31'b0, MemWrite_M}, 32'h1);
    @(negedge clk);
    drive_alu(ALU_ADD, 32'h2, 32'h3, 5'd6);
    ForwardA_E = 2'b11; ForwardB_E = 2'b11; Result_W = 32'h77;
    @(posedge clk); #1 chk("fwd.code11", ALUResult_M, 32'h5);
    @(negedge clk);
    idle_inputs();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
